// File: rtl/booth_mult_8_bit.sv
// booth_mult_8_bit: sequential radix-2 Booth multiplier, signed 8x8 -> 16.
// Each of the 8 iterations uses an external combinational 8-bit
// adder/subtractor. This block holds only the control, the accumulator and
// the shift datapath.
// Optional feature: define BOOTH_MULT_ABORT_EN to add an `abort` input that
// cancels a running calculation without producing a result.
module booth_mult_8_bit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  multiplicand,
  input  logic [7:0]  multiplier,
`ifdef BOOTH_MULT_ABORT_EN
  input  logic        abort,
`endif
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic [7:0]  add_a,
  output logic [7:0]  add_b,
  output logic        add_sel,
  output logic        add_c_in,
  input  logic [7:0]  add_sum,
  input  logic        add_ovf
);

  typedef enum logic {IDLE, CALC} state_t;

  state_t      state;
  logic [7:0]  a;
  logic [7:0]  q;
  logic        q_m1;
  logic [7:0]  m;
  logic [3:0]  cnt;

  logic        arith;
  logic [7:0]  n_val;
  logic        sign_in;
  logic [7:0]  a_next;
  logic [7:0]  q_next;

  // The adder sees the registered accumulator and multiplicand directly.
  assign add_a = a;
  assign add_b = m;

  // Booth decode of {Q[0], q_m1} and the arithmetic shift of {N, Q, q_m1}.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    arith    = 1'b0;
    add_sel  = 1'b0;
    n_val    = a;
    sign_in  = a[7];
    case ({q[0], q_m1})
      2'b01: begin
        arith = 1'b1;
      end
      2'b10: begin
        arith   = 1'b1;
        add_sel = 1'b1;
      end
      default: ;
    endcase
    if (arith) begin
      n_val   = add_sum;
      // The raw sum bit is wrong on overflow; xor with it restores the true
      // sign, which matters for M = -128.
      sign_in = add_sum[7] ^ add_ovf;
    end
    add_c_in = add_sel;
    a_next   = {sign_in, n_val[7:1]};
    q_next   = {n_val[0], q[7:1]};
  end

  // Control FSM, operand capture, iteration and result register.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the values from before this edge, whatever the statement order.
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= 16'h0000;
      a       <= 8'h00;
      q       <= 8'h00;
      q_m1    <= 1'b0;
      m       <= 8'h00;
      cnt     <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a     <= 8'h00;
            q     <= multiplier;
            q_m1  <= 1'b0;
            m     <= multiplicand;
            cnt   <= 4'd0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
`ifdef BOOTH_MULT_ABORT_EN
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
`endif
            a    <= a_next;
            q    <= q_next;
            q_m1 <= q[0];
            cnt  <= cnt + 4'd1;
            if (cnt == 4'd7) begin
              product <= {a_next, q_next};
              done    <= 1'b1;
              busy    <= 1'b0;
              state   <= IDLE;
            end
`ifdef BOOTH_MULT_ABORT_EN
          end
`endif
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
